// File: rtl/collision_scheduler.sv
// Collision scheduler: scans a table of N_OBJ target boxes against a latched
// player box, one slot per cycle through a single shared comparator.
// Optional build macro CSCHED_TRUE_AABB_EN selects a true interval-overlap
// test; without it a hit needs a player edge inside the slot span on both axes.
module collision_scheduler #(
  parameter int unsigned N_OBJ = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [9:0]       p_x,
  input  logic [9:0]       p_y,
  input  logic [9:0]       p_w,
  input  logic [9:0]       p_h,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [9:0]       wr_x,
  input  logic [9:0]       wr_y,
  input  logic [9:0]       wr_w,
  input  logic [9:0]       wr_h,
  output logic             busy,
  output logic             done,
  output logic [N_OBJ-1:0] hit_mask,
  output logic             hit_any,
  output logic [IDX_W-1:0] first_hit,
  output logic             wr_err
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [N_OBJ-1:0]   acc_q;
  logic [9:0]         px_q, py_q, pw_q, ph_q;
  logic [N_OBJ-1:0]   valid_q;
  logic [9:0]         s_x_q [N_OBJ];
  logic [9:0]         s_y_q [N_OBJ];
  logic [9:0]         s_w_q [N_OBJ];
  logic [9:0]         s_h_q [N_OBJ];
  logic [N_OBJ-1:0]   hit_mask_q;
  logic               hit_any_q;
  logic [IDX_W-1:0]   first_hit_q;
  logic               wr_err_q;

  logic               start_ok;
  logic               wr_ok;
  logic               last_slot;
  logic [10:0]        p_x0, p_x1, p_y0, p_y1;
  logic [10:0]        s_x0, s_x1, s_y0, s_y1;
  logic               x_cond, y_cond, slot_hit;
  logic [N_OBJ-1:0]   mask_next;
  logic [IDX_W-1:0]   first_next;

  assign start_ok  = (state_q == StIdle) && start;
  // Writes to indices beyond the table (non power-of-two N_OBJ) are ignored.
  assign wr_ok     = (state_q == StIdle) && wr_en && (32'(wr_idx) < N_OBJ);
  assign last_slot = (idx_q == IDX_W'(N_OBJ - 1));

  // Edges are formed at 11 bits so x+w never wraps back into range.
  assign p_x0 = {1'b0, px_q};
  assign p_x1 = {1'b0, px_q} + {1'b0, pw_q};
  assign p_y0 = {1'b0, py_q};
  assign p_y1 = {1'b0, py_q} + {1'b0, ph_q};
  assign s_x0 = {1'b0, s_x_q[idx_q]};
  assign s_x1 = {1'b0, s_x_q[idx_q]} + {1'b0, s_w_q[idx_q]};
  assign s_y0 = {1'b0, s_y_q[idx_q]};
  assign s_y1 = {1'b0, s_y_q[idx_q]} + {1'b0, s_h_q[idx_q]};

  // Shared box comparator for the slot selected by the scan index.
  always_comb begin
`ifdef CSCHED_TRUE_AABB_EN
    x_cond = (p_x0 <= s_x1) && (s_x0 <= p_x1);
    y_cond = (p_y0 <= s_y1) && (s_y0 <= p_y1);
`else
    x_cond = ((p_x0 >= s_x0) && (p_x0 <= s_x1)) || ((p_x1 >= s_x0) && (p_x1 <= s_x1));
    y_cond = ((p_y0 >= s_y0) && (p_y0 <= s_y1)) || ((p_y1 >= s_y0) && (p_y1 <= s_y1));
`endif
    slot_hit = valid_q[idx_q] && x_cond && y_cond;
  end

  // Accumulator including the current slot, and its lowest set index.
  always_comb begin
    mask_next         = acc_q;
    mask_next[idx_q]  = slot_hit;
    first_next        = '0;
    for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
      if (mask_next[i]) first_next = IDX_W'(i);
    end
  end

  // Next-state logic for the IDLE/SCAN/DONE sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (last_slot) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register, scan index, accumulator and latched player box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pw_q    <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        idx_q <= '0;
        acc_q <= '0;
        px_q  <= p_x;
        py_q  <= p_y;
        pw_q  <= p_w;
        ph_q  <= p_h;
      end else if (state_q == StScan) begin
        idx_q <= idx_q + 1'b1;
        acc_q <= mask_next;
      end
    end
  end

  // Published results change only when the final slot has been evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_mask_q  <= '0;
      hit_any_q   <= 1'b0;
      first_hit_q <= '0;
    end else if ((state_q == StScan) && last_slot) begin
      hit_mask_q  <= mask_next;
      hit_any_q   <= |mask_next;
      first_hit_q <= first_next;
    end
  end

  // Dropped-write flag and slot valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
      valid_q  <= '0;
    end else begin
      wr_err_q <= wr_en && (state_q != StIdle);
      if (wr_ok) valid_q[wr_idx] <= wr_valid;
    end
  end

  // Slot coordinates carry no reset; validity alone gates their use.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      s_x_q[wr_idx] <= wr_x;
      s_y_q[wr_idx] <= wr_y;
      s_w_q[wr_idx] <= wr_w;
      s_h_q[wr_idx] <= wr_h;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign hit_mask  = hit_mask_q;
  assign hit_any   = hit_any_q;
  assign first_hit = first_hit_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: each accepted scan pushes its
// expected result and done cycle; a monitor pops and compares on done.
module tb_collision_scheduler;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [9:0]   p_x, p_y, p_w, p_h;
  logic         wr_en;
  logic [W-1:0] wr_idx;
  logic         wr_valid;
  logic [9:0]   wr_x, wr_y, wr_w, wr_h;
  logic         busy, done, hit_any, wr_err;
  logic [N-1:0] hit_mask;
  logic [W-1:0] first_hit;

  collision_scheduler #(.N_OBJ(N), .IDX_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .p_x(p_x), .p_y(p_y), .p_w(p_w), .p_h(p_h),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
    .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h),
    .busy(busy), .done(done), .hit_mask(hit_mask), .hit_any(hit_any),
    .first_hit(first_hit), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mask;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Shadow of the slot table as the bench believes it was written.
  int sh_v[N], sh_x[N], sh_y[N], sh_w[N], sh_h[N];

  function automatic bit axis_hit(int a, int al, int b, int bl);
`ifdef CSCHED_TRUE_AABB_EN
    return (a <= b + bl) && (b <= a + al);
`else
    return ((a >= b) && (a <= b + bl)) || ((a + al >= b) && (a + al <= b + bl));
`endif
  endfunction

  function automatic logic [N-1:0] model_mask(int px, int py, int pw, int ph);
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (sh_v[i] != 0) && axis_hit(px, pw, sh_x[i], sh_w[i])
             && axis_hit(py, ph, sh_y[i], sh_h[i]);
    end
    return m;
  endfunction

  function automatic int lowest(logic [N-1:0] m);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = sb.pop_front();
        total++;
        if (cyc !== mon_e.cyc) begin
          bad++;
          $display("FAIL done_cycle: got %0d required %0d", cyc, mon_e.cyc);
        end
        total++;
        if (hit_mask !== mon_e.mask) begin
          bad++;
          $display("FAIL hit_mask: got %h required %h", hit_mask, mon_e.mask);
        end
        total++;
        if (hit_any !== (|mon_e.mask)) begin
          bad++;
          $display("FAIL hit_any: got %b required %b", hit_any, |mon_e.mask);
        end
        total++;
        if (first_hit !== W'(lowest(mon_e.mask))) begin
          bad++;
          $display("FAIL first_hit: got %0d required %0d", first_hit, lowest(mon_e.mask));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(int i, bit v, int x, int y, int w, int h);
    wr_idx   = W'(i);
    wr_valid = v;
    wr_x     = 10'(x);
    wr_y     = 10'(y);
    wr_w     = 10'(w);
    wr_h     = 10'(h);
  endtask

  task automatic write_slot(int i, bit v, int x, int y, int w, int h);
    set_wr(i, v, x, y, w, h);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    sh_v[i] = v;
    sh_x[i] = x;
    sh_y[i] = y;
    sh_w[i] = w;
    sh_h[i] = h;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) write_slot(i, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic set_player(int x, int y, int w, int h);
    p_x = 10'(x);
    p_y = 10'(y);
    p_w = 10'(w);
    p_h = 10'(h);
  endtask

  // Pulses start for one cycle; optionally records the expected result.
  task automatic do_start(int x, int y, int w, int h, logic [N-1:0] m, bit expect_done);
    set_player(x, y, w, h);
    start = 1'b1;
    if (expect_done) sb.push_back('{mask: m, cyc: cyc + N + 1});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", done); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL rst_wr_err: got %b required 0", wr_err); end
    total++; if (hit_mask !== '0) begin bad++; $display("FAIL rst_mask: got %h required 00", hit_mask); end
    total++; if (hit_any !== 1'b0) begin bad++; $display("FAIL rst_any: got %b required 0", hit_any); end
    total++; if (first_hit !== '0) begin bad++; $display("FAIL rst_first: got %0d required 0", first_hit); end
  endtask

  task automatic test_basic();
    bit ok;
    clear_table();
    write_slot(2, 1'b1, 110, 110, 20, 20);
    do_start(100, 100, 20, 20, 8'h04, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b required 1", busy); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: busy stuck, required idle"); end
  endtask

  task automatic test_contained();
    bit ok;
    logic [N-1:0] e;
`ifdef CSCHED_TRUE_AABB_EN
    e = 8'h20;
`else
    e = 8'h00;
`endif
    clear_table();
    write_slot(5, 1'b1, 10, 10, 5, 5);
    do_start(0, 0, 50, 50, e, 1'b1);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL contain_timeout: busy stuck, required idle"); end
  endtask

  task automatic test_edges();
    bit ok;
    clear_table();
    write_slot(0, 1'b1, 0, 0, 10, 10);
    do_start(1000, 1000, 20, 20, 8'h00, 1'b1);
    wait_idle(ok);
    // 1010+20 would wrap to 6 in 10 bits and land inside slot 0.
    do_start(1010, 1010, 20, 20, 8'h00, 1'b1);
    wait_idle(ok);
    write_slot(3, 1'b1, 20, 20, 5, 5);
    do_start(10, 10, 10, 10, 8'h09, 1'b1);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL edges_timeout: busy stuck, required idle"); end
  endtask

  task automatic test_random();
    bit ok;
    int x, y, w, h;
    for (int i = 0; i < N; i++) begin
      write_slot(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 300),
                 $urandom_range(0, 300), $urandom_range(0, 100), $urandom_range(0, 100));
    end
    for (int s = 0; s < 6; s++) begin
      x = $urandom_range(0, 300);
      y = $urandom_range(0, 300);
      w = $urandom_range(0, 120);
      h = $urandom_range(0, 120);
      do_start(x, y, w, h, model_mask(x, y, w, h), 1'b1);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_timeout: scan %0d stuck", s); end
    end
  endtask

  task automatic test_scan_guard();
    bit ok;
    clear_table();
    write_slot(1, 1'b1, 100, 100, 20, 20);
    do_start(105, 105, 10, 10, 8'h02, 1'b1);
    tick();
    tick();
    // SCAN cycle 3: this write must be dropped.
    set_wr(4, 1'b1, 105, 105, 10, 10);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wr_err_pulse: got %b required 1", wr_err); end
    set_player(305, 305, 10, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL wr_err_width: got %b required 0", wr_err); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL guard_timeout: busy stuck, required idle"); end
    do_start(105, 105, 10, 10, model_mask(105, 105, 10, 10), 1'b1);
    wait_idle(ok);
  endtask

  task automatic test_coincide();
    bit ok;
    set_wr(7, 1'b1, 200, 200, 10, 10);
    wr_en = 1'b1;
    sh_v[7] = 1; sh_x[7] = 200; sh_y[7] = 200; sh_w[7] = 10; sh_h[7] = 10;
    do_start(205, 205, 10, 10, 8'h80, 1'b1);
    wr_en = 1'b0;
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL coincide_wr_err: got %b required 0", wr_err); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(105, 105, 10, 10, '0, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b required 0", done); end
    total++; if (hit_mask !== '0) begin bad++; $display("FAIL midrst_mask: got %h required 00", hit_mask); end
    total++; if (hit_any !== 1'b0) begin bad++; $display("FAIL midrst_any: got %b required 0", hit_any); end
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) sh_v[i] = 0;
    tick();
    do_start(105, 105, 10, 10, 8'h00, 1'b1);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_timeout: busy stuck, required idle"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c0;
    write_slot(1, 1'b1, 100, 100, 20, 20);
    write_slot(6, 1'b1, 300, 300, 20, 20);
    c0 = cyc;
    do_start(105, 105, 10, 10, 8'h02, 1'b1);
    for (int k = 0; k < 40 && cyc < c0 + N + 2; k++) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: busy=%b required 0", busy); end
    do_start(305, 305, 10, 10, 8'h40, 1'b1);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: busy stuck, required idle"); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    set_wr(0, 1'b0, 0, 0, 0, 0);
    set_player(0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      sh_v[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0;
    end
    #12;
    test_reset();
    #11;
    rst_n = 1'b1;
    tick();
    test_basic();
    test_contained();
    test_edges();
    test_random();
    test_scan_guard();
    test_coincide();
    test_reset_mid();
    test_back_to_back();
    tick();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_scans: %0d done pulses missing, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 SHALL have parameter N_OBJ, default 8, number of target object slots (2..16).
REQ-002 SHALL have parameter IDX_W, default 3, slot index width (clog2 of N_OBJ).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  frame scan request pulse.
REQ-006 SHALL have ports p_x, p_y, p_w, p_h  in  10 each  player box, sampled on accepted start.
REQ-007 SHALL have ports wr_en  in  1; wr_idx  in  IDX_W; wr_valid  in  1; wr_x, wr_y, wr_w, wr_h  in  10 each  slot table write.
REQ-008 SHALL have port busy  out  1  scan in progress.
REQ-009 SHALL have port done  out  1  one-cycle scan-complete pulse.
REQ-010 SHALL have port hit_mask  out  N_OBJ  per-slot collision result of last scan.
REQ-011 SHALL have ports hit_any  out  1 (OR of hit_mask) and first_hit  out  IDX_W (lowest hit index, 0 if none).
REQ-012 SHALL have port wr_err  out  1  one-cycle pulse when a write is dropped.

Function
REQ-013 SHALL hold N_OBJ slots of {valid, x, y, w, h}; wr_en in IDLE writes slot wr_idx next edge.
REQ-014 SHALL drop wr_en while busy=1, pulse wr_err next cycle, leave the table unchanged.
REQ-015 SHALL use one shared box comparator, evaluating exactly one slot per cycle.
REQ-016 SHALL implement states IDLE, SCAN, DONE: IDLE->SCAN on start; SCAN->DONE after slot N_OBJ-1; DONE->IDLE unconditionally.
REQ-017 SHALL latch p_x/p_y/p_w/p_h and clear the scan index and result accumulator on the start edge in IDLE.
REQ-018 SHALL ignore start while in SCAN or DONE (no restart, no queuing).
REQ-019 SHALL assert busy in SCAN and DONE, deassert in IDLE.
REQ-020 SHALL evaluate slot i in SCAN cycle i (i=0..N_OBJ-1); invalid slots SHALL yield 0.
REQ-021 SHALL compute box edges (x+w, y+h) at 11 bits; no 10-bit wrap-around.
REQ-022 SHALL define default hit as (X-cond AND Y-cond), X-cond true if p_x or p_x+p_w lies in [s_x, s_x+s_w] inclusive; Y-cond likewise on y/h.
REQ-023 SHALL update hit_mask, hit_any, first_hit together on the SCAN->DONE edge and hold them until the next such edge.
REQ-024 SHALL assert done for exactly the DONE cycle; done rises N_OBJ+1 cycles after the start edge.
REQ-025 SHALL permit start in the cycle after DONE (back-to-back scans every N_OBJ+2 cycles).
REQ-026 SHALL, when start and wr_en coincide in IDLE, perform the write and start the scan, the scan seeing the written value.

Reset
REQ-027 SHALL on rst_n low immediately force IDLE, busy=0, done=0, wr_err=0, hit_mask=0, hit_any=0, first_hit=0, all slot valid=0.
REQ-028 SHALL abort any scan on mid-scan reset without a done pulse; slot coordinates need not be cleared.
REQ-029 SHALL release reset synchronously to clk with first start accepted on the first edge after rst_n high.

Configuration
REQ-030 SHALL with macro CSCHED_TRUE_AABB_EN defined use interval overlap: hit iff p_x<=s_x+s_w AND s_x<=p_x+p_w AND p_y<=s_y+s_h AND s_y<=p_y+p_h (11-bit).
REQ-031 SHALL without CSCHED_TRUE_AABB_EN use the edge-in-range rule of REQ-022 (slot fully inside player horizontally or vertically reports no hit).
REQ-032 SHALL keep timing, latency and interface identical in both configurations.

Verification
REQ-033 Player (100,100,20,20), slot 2 valid (110,110,20,20), others invalid, start -> done at cycle 9, hit_mask=0x04, hit_any=1, first_hit=2.
REQ-034 Player (0,0,50,50), slot 5 (10,10,5,5): with CSCHED_TRUE_AABB_EN -> hit_mask=0x20; without -> hit_mask=0x00.
REQ-035 Player (1000,1000,20,20), slot 0 (0,0,10,10) -> hit_mask=0x00 (no wrap false hit); touching boxes (10,10,10,10) vs (20,20,5,5) -> hit.
REQ-036 wr_en during SCAN -> wr_err pulse next cycle, table unchanged; start during SCAN -> ignored, single done.
REQ-037 rst_n low at SCAN cycle 3 -> busy=0 immediately, no done, hit_mask=0, valids cleared.
REQ-038 Two starts in cycles 0 and 10 (N_OBJ=8) -> two done pulses at cycles 9 and 19, results of each scan independent.
